// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Single-stage instruction fetch with an IF/ID pipeline register. A
// registered PC drives the instruction memory address. The combinational
// read data is captured into IF/ID on the next rising edge, so fetch latency
// is one cycle. The PC wraps to 0 after the last legal word (PC_LIMIT-4).
//
// Handshake: stall is a ready-low backpressure signal from downstream. While
// it is high, nothing moves: the PC and IF/ID hold and the stalled cycle is
// counted. branch_taken is a single-cycle redirect request that wins over
// stall. A legal redirect flushes IF/ID (valid=0) and restarts fetch at the
// target. An illegal redirect (misaligned, or outside memory) raises the
// sticky fetch_error and parks the block in HALT until reset.
//
// Ports
//   clk              : clock, rising edge
//   reset            : asynchronous, active-low reset
//   stall            : downstream not ready; hold PC and IF/ID
//   branch_taken     : redirect request
//   branch_target    : redirect byte address (64)
//   Inst_Address     : instruction memory address, equals registered PC (64)
//   Instruction      : combinational memory read data for Inst_Address (32)
//   IFID_PC          : PC of the latched instruction (64)
//   IFID_Instruction : latched instruction (32)
//   IFID_valid       : IF/ID holds a real instruction
//   fetch_error      : sticky illegal-redirect flag
//   fetch_count      : number of valid IF/ID loads, wraps modulo 2^32
//   stall_count      : number of stalled cycles, saturates at 16'hFFFF
//   o_dbg_state      : current FSM state (0 IDLE, 1 RUN, 2 HOLD, 3 HALT)
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] PC_LIMIT = 64'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] Inst_Address,
  input  logic [31:0] Instruction,
  output logic [63:0] IFID_PC,
  output logic [31:0] IFID_Instruction,
  output logic        IFID_valid,
  output logic        fetch_error,
  output logic [31:0] fetch_count,
  output logic [15:0] stall_count,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [63:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_ifid_valid;
  logic        r_fetch_error;
  logic [31:0] r_fetch_count;
  logic [15:0] r_stall_count;

  logic        w_target_legal;
  logic [63:0] w_pc_next;

  // A target is usable only if word aligned and inside instruction memory.
  assign w_target_legal = (branch_target[1:0] == 2'b00) && (branch_target < PC_LIMIT);

  // Sequential fetch wraps back to address 0 after the last word.
  assign w_pc_next = (r_pc == (PC_LIMIT - 64'd4)) ? 64'd0 : (r_pc + 64'd4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC;
      r_ifid_pc     <= 64'd0;
      r_ifid_instr  <= 32'd0;
      r_ifid_valid  <= 1'b0;
      r_fetch_error <= 1'b0;
      r_fetch_count <= 32'd0;
      r_stall_count <= 16'd0;
    end else begin
      case (r_state)
        // One settling cycle after reset; redirects are ignored here.
        IDLE: r_state <= RUN;

        RUN, HOLD: begin
          if (branch_taken) begin
            r_ifid_valid <= 1'b0;
            if (w_target_legal) begin
              r_pc    <= branch_target;
              r_state <= RUN;
            end else begin
              r_fetch_error <= 1'b1;
              r_state       <= HALT;
            end
          end else if (stall) begin
            r_state <= HOLD;
            if (r_stall_count != 16'hFFFF) begin
              r_stall_count <= r_stall_count + 16'd1;
            end
          end else if (r_state == RUN) begin
            r_ifid_pc     <= r_pc;
            r_ifid_instr  <= Instruction;
            r_ifid_valid  <= 1'b1;
            r_fetch_count <= r_fetch_count + 32'd1;
            r_pc          <= w_pc_next;
          end else begin
            // Leaving HOLD spends one edge without loading; the held PC is
            // fetched on the following RUN edge.
            r_state <= RUN;
          end
        end

        // Only reset leaves HALT. IFID_valid was already cleared on entry.
        HALT: r_state <= HALT;

        default: r_state <= IDLE;
      endcase
    end
  end

  assign Inst_Address     = r_pc;
  assign IFID_PC          = r_ifid_pc;
  assign IFID_Instruction = r_ifid_instr;
  assign IFID_valid       = r_ifid_valid;
  assign fetch_error      = r_fetch_error;
  assign fetch_count      = r_fetch_count;
  assign stall_count      = r_stall_count;
  assign o_dbg_state      = r_state;

endmodule
